// File: rtl/rx_byte_fifo.sv
// UART receive-side byte FIFO: a three-state capture FSM handshakes with the receiver
// (rdy/clr_rdy) and feeds a first-word-fall-through FIFO. Define RXF_WATERMARK_EN to add almost_full.
module rx_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic [7:0]    rx_data,
  output logic          clr_rdy,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overrun,
  input  logic          clr_ovr
`ifdef RXF_WATERMARK_EN
  ,
  output logic          almost_full
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_ARM, S_WAIT, S_ACK} state_t;

  state_t        state, state_nx;
  logic [7:0]    hold;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, wr_ok, drop;

  always_comb begin
    state_nx = state;
    case (state)
      S_ARM:   if (!rdy) state_nx = S_WAIT;
      S_WAIT:  if (rdy)  state_nx = S_ACK;
      S_ACK:   state_nx = S_ARM;
      default: state_nx = S_ARM;
    endcase
  end

  // The byte is latched on leaving WAIT and committed at the end of ACK, so a
  // reset landing during ACK discards it together with the acknowledge.
  assign push  = (state == S_ACK);
  assign pop   = rd_en && !empty;
  assign wr_ok = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_data = mem[rd_ptr];

`ifdef RXF_WATERMARK_EN
  assign almost_full = (count >= CW'(DEPTH - 2));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_ARM;
      clr_rdy <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      clr_rdy <= push;
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_WAIT && rdy) hold <= rx_data;
    if (wr_ok && !rst)          mem[wr_ptr] <= hold;
  end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Scoreboard bench for rx_byte_fifo (DEPTH=8): bytes are queued as expected when
// driven and compared on each pop; handshake timing and flags are checked per scenario.
module tb_rx_byte_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst, rdy, rd_en, clr_ovr;
  logic [7:0]    rx_data;
  logic          clr_rdy, empty, full, overrun;
  logic [7:0]    rd_data;
  logic [CW-1:0] cnt;
`ifdef RXF_WATERMARK_EN
  logic          almost_full;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pulses   = 0;
  logic [7:0]  sb [$];

  rx_byte_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .rx_data (rx_data),
    .clr_rdy (clr_rdy),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (cnt),
    .overrun (overrun),
    .clr_ovr (clr_ovr)
`ifdef RXF_WATERMARK_EN
    ,
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (clr_rdy) pulses++;

  // Drive one frame; lat = negedges from rdy rise until clr_rdy seen (0 on timeout).
  task automatic send_byte(input logic [7:0] b, output int lat);
    @(negedge clk); rdy = 1'b0; rx_data = b;
    @(negedge clk); rdy = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (clr_rdy) begin lat = i; break; end
    end
    rdy = 1'b0;
    if (sb.size() < DEPTH) sb.push_back(b);
  endtask

  task automatic do_pop(output logic [7:0] got, output logic [7:0] exp);
    got = rd_data;
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    int unsigned p0;
    rdy = 1'b1; rx_data = 8'h3C;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    p0 = pulses;
    repeat (20) @(negedge clk);
    n_checks++; if (pulses !== p0) begin n_fail++; $display("FAIL reset_no_ack: pulses %0d, required %0d", pulses - p0, 0); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b, required 1", empty); end
    n_checks++; if (cnt !== '0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", cnt); end
    n_checks++; if (full !== 1'b0 || overrun !== 1'b0 || clr_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: full=%b overrun=%b clr_rdy=%b, required 0 0 0", full, overrun, clr_rdy); end
    rdy = 1'b0;
  endtask

  task automatic test_single();
    int lat; logic [7:0] got, exp;
    send_byte(8'hA5, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL single_latency: got %0d, required 2", lat); end
    n_checks++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_rd_data: got %h, required a5", rd_data); end
    n_checks++; if (cnt !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d, required 1", cnt); end
    @(negedge clk);
    n_checks++; if (clr_rdy !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: clr_rdy %b, required 0", clr_rdy); end
    do_pop(got, exp);
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL single_pop: got %h, required %h", got, exp); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_after_pop: got %b, required 1", empty); end
  endtask

  task automatic test_overrun();
    int lat; int unsigned p0; logic [7:0] got, exp;
    apply_reset();
    p0 = pulses;
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), lat);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL ovr_latency[%0d]: got %0d, required 2", i, lat); end
    end
    @(negedge clk);
    n_checks++; if (pulses - p0 !== 9) begin n_fail++; $display("FAIL ovr_pulses: got %0d, required 9", pulses - p0); end
    n_checks++; if (full !== 1'b1 || cnt !== 4'd8) begin n_fail++; $display("FAIL ovr_full: full=%b count=%0d, required 1 8", full, cnt); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b, required 1", overrun); end
    for (int i = 0; i < 8; i++) begin
      do_pop(got, exp);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL ovr_pop[%0d]: got %h, required %h", i, got, exp); end
    end
    n_checks++; if (empty !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: empty=%b overrun=%b, required 1 1", empty, overrun); end
    clr_ovr = 1'b1; @(negedge clk); clr_ovr = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b, required 0", overrun); end
  endtask

  task automatic test_full_pop();
    int lat; logic [7:0] got, exp, last;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) send_byte(8'h80 + 8'(i), lat);
    @(negedge clk); rdy = 1'b0; rx_data = 8'h55;
    @(negedge clk); rdy = 1'b1;
    @(negedge clk);
    got = rd_data; exp = sb.pop_front(); rd_en = 1'b1;
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL fp_head: got %h, required %h", got, exp); end
    sb.push_back(8'h55);
    @(negedge clk); rd_en = 1'b0;
    n_checks++; if (clr_rdy !== 1'b1) begin n_fail++; $display("FAIL fp_ack: clr_rdy %b, required 1", clr_rdy); end
    rdy = 1'b0;
    @(negedge clk);
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fp_overrun: got %b, required 0", overrun); end
    n_checks++; if (cnt !== 4'd8) begin n_fail++; $display("FAIL fp_count: got %0d, required 8", cnt); end
    last = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      do_pop(got, exp);
      last = got;
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL fp_pop[%0d]: got %h, required %h", i, got, exp); end
    end
    n_checks++; if (last !== 8'h55) begin n_fail++; $display("FAIL fp_last: got %h, required 55", last); end
  endtask

  task automatic test_wrap();
    int lat; logic [7:0] got, exp;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      send_byte(8'hC0 ^ 8'(i * 7), lat);
      @(negedge clk);
      n_checks++; if (cnt !== CW'(sb.size())) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d, required %0d", i, cnt, sb.size()); end
`ifdef RXF_WATERMARK_EN
      n_checks++; if (almost_full !== (sb.size() >= DEPTH - 2)) begin n_fail++; $display("FAIL wrap_af[%0d]: got %b, required %b", i, almost_full, sb.size() >= DEPTH - 2); end
`endif
      if (i >= 6) begin
        do_pop(got, exp);
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL wrap_pop[%0d]: got %h, required %h", i, got, exp); end
      end
    end
    while (sb.size() > 0) begin
`ifdef RXF_WATERMARK_EN
      n_checks++; if (almost_full !== (sb.size() >= DEPTH - 2)) begin n_fail++; $display("FAIL drain_af: got %b, required %b", almost_full, sb.size() >= DEPTH - 2); end
`endif
      do_pop(got, exp);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL drain_pop: got %h, required %h", got, exp); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b, required 1", empty); end
  endtask

  task automatic test_reset_ack();
    int unsigned p0; int lat; logic [7:0] got, exp;
    @(negedge clk); rdy = 1'b0; rx_data = 8'h77;
    @(negedge clk); rdy = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_checks++; if (clr_rdy !== 1'b0) begin n_fail++; $display("FAIL rack_clr_rdy: got %b, required 0", clr_rdy); end
    n_checks++; if (cnt !== '0 || empty !== 1'b1) begin n_fail++; $display("FAIL rack_discard: count=%0d empty=%b, required 0 1", cnt, empty); end
    p0 = pulses;
    rd_en = 1'b1;
    repeat (5) @(negedge clk);
    rd_en = 1'b0;
    n_checks++; if (pulses !== p0 || cnt !== '0) begin n_fail++; $display("FAIL rack_rearm: pulses %0d count %0d, required 0 0", pulses - p0, cnt); end
    sb.delete();
    send_byte(8'h3E, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rack_resume_latency: got %0d, required 2", lat); end
    do_pop(got, exp);
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rack_resume_pop: got %h, required %h", got, exp); end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_overrun();
    test_full_pop();
    test_wrap();
    test_reset_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
